cam_capture_param: RTL and testbench

Parametrised OV7670 capture engine for the camera domain. Assembles byte pairs from the sensor bus into pixels, converts them to a run-time-selected storage format, and optionally decimates them. It produces a write strobe, a linear frame-buffer address and per-frame status. It sits between the sensor pins and the capture-side FIFO/VRAM write port, and supersedes the fixed 640x480 RGB565 capture block.

---
 rtl/cam_capture_pkg.sv | 38 +++
 rtl/cam_pixel_pack.sv | 39 +++
 rtl/cam_capture_param.sv | 134 +++++++++++++
 tb/tb_cam_capture_param.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_capture_pkg.sv
// Shared types and helpers for the OV7670 capture engine.
package cam_capture_pkg;

  typedef enum logic [1:0] {
    MODE_RGB565 = 2'd0,
    MODE_RGB444 = 2'd1,
    MODE_Y      = 2'd2,
    MODE_RSVD   = 2'd3
  } cap_mode_e;

  typedef enum logic [1:0] {
    DECIM_1  = 2'd0,
    DECIM_2  = 2'd1,
    DECIM_4  = 2'd2,
    DECIM_4B = 2'd3
  } cap_decim_e;

  typedef enum logic [1:0] {
    S_SYNC,
    S_VBLANK,
    S_SKIP,
    S_FRAME
  } cap_state_e;

  function automatic logic [15:0] rgb565_to_444(input logic [15:0] pix);
    return {4'h0, pix[15:12], pix[10:7], pix[4:1]};
  endfunction

  // Low col/row bits that must be zero for a pixel to be kept.
  function automatic logic [1:0] decim_mask(input cap_decim_e dec);
    case (dec)
      DECIM_1: return 2'b00;
      DECIM_2: return 2'b01;
      default: return 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/cam_pixel_pack.sv
// Pairs sensor bytes into pixels and registers the converted storage word.
module cam_pixel_pack
  import cam_capture_pkg::*;
(
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        byte_en,
  input  cap_mode_e   mode,
  input  logic [7:0]  d,
  output logic        phase,
  output logic [15:0] dout
);

  logic [7:0] hi;

  // Any cycle without an accepted byte drops a pending half-pixel.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      phase <= 1'b0;
      hi    <= '0;
      dout  <= '0;
    end else if (byte_en) begin
      if (!phase) begin
        hi    <= d;
        phase <= 1'b1;
      end else begin
        phase <= 1'b0;
        case (mode)
          MODE_RGB444: dout <= rgb565_to_444({hi, d});
          MODE_Y:      dout <= {8'h00, hi};
          default:     dout <= {hi, d};
        endcase
      end
    end else begin
      phase <= 1'b0;
    end
  end

endmodule

// File: rtl/cam_capture_param.sv
// OV7670 capture engine: frame FSM, decimation, frame-buffer addressing and
// per-frame status around the cam_pixel_pack byte pairer.
module cam_capture_param
  import cam_capture_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int ADDR_W    = 17,
  parameter int BUF_DEPTH = 76800
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [1:0]        decim,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  output logic              wr,
  output logic [ADDR_W-1:0] addr,
  output logic [15:0]       dout,
  output logic              frame_done,
  output logic [15:0]       frame_cnt,
  output logic [ADDR_W-1:0] last_words,
  output logic              overflow,
  output logic              byte_err
);

  localparam int COL_W = ($clog2(H_ACTIVE + 1) < 2) ? 2 : $clog2(H_ACTIVE + 1);
  localparam int ROW_W = ($clog2(V_ACTIVE + 1) < 2) ? 2 : $clog2(V_ACTIVE + 1);
  localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(BUF_DEPTH);

  cap_state_e        state, state_next;
  cap_mode_e         mode_q;
  cap_decim_e        decim_q;
  logic              line_act;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] wcnt;
  logic              phase;
  logic              byte_en, pair_done, href_fall, frame_start, frame_end;
  logic              keep;
  logic [1:0]        mask;

  assign byte_en     = (state == S_FRAME) && !vsync && href;
  assign pair_done   = byte_en && phase;
  assign href_fall   = (state == S_FRAME) && !vsync && line_act && !href;
  assign frame_start = (state == S_VBLANK) && !vsync;
  assign frame_end   = (state == S_FRAME) && vsync;
  assign mask        = decim_mask(decim_q);
  assign keep        = ((col & COL_W'(mask)) == '0) && ((row & ROW_W'(mask)) == '0);

  cam_pixel_pack u_pack (
    .pclk    (pclk),
    .rst_n   (rst_n),
    .byte_en (byte_en),
    .mode    (mode_q),
    .d       (d),
    .phase   (phase),
    .dout    (dout)
  );

  always_ff @(posedge pclk) begin
    if (!rst_n) state <= S_SYNC;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_SYNC:   if (vsync)  state_next = S_VBLANK;
      S_VBLANK: if (!vsync) state_next = en ? S_FRAME : S_SKIP;
      S_SKIP:   if (vsync)  state_next = S_VBLANK;
      S_FRAME:  if (vsync)  state_next = S_VBLANK;
      default:              state_next = S_SYNC;
    endcase
  end

  // line_act only tracks bytes accepted inside a frame, so a line that was
  // cut by vsync or straddled frame start never produces a row step.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      wr         <= 1'b0;
      addr       <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      last_words <= '0;
      overflow   <= 1'b0;
      byte_err   <= 1'b0;
      mode_q     <= MODE_RGB565;
      decim_q    <= DECIM_1;
      line_act   <= 1'b0;
      col        <= '0;
      row        <= '0;
      wcnt       <= '0;
    end else begin
      wr         <= 1'b0;
      frame_done <= 1'b0;
      line_act   <= byte_en;
      if (frame_start) begin
        mode_q   <= cap_mode_e'(mode);
        decim_q  <= cap_decim_e'(decim);
        wcnt     <= '0;
        col      <= '0;
        row      <= '0;
        overflow <= 1'b0;
        byte_err <= 1'b0;
      end
      if (pair_done) begin
        col <= col + 1'b1;
        if (keep) begin
          if (wcnt < DEPTH) begin
            wr   <= 1'b1;
            addr <= wcnt;
            wcnt <= wcnt + 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end
      end
      if (href_fall) begin
        col <= '0;
        row <= row + 1'b1;
        if (phase) byte_err <= 1'b1;
      end
      if (frame_end) begin
        frame_done <= 1'b1;
        frame_cnt  <= frame_cnt + 1'b1;
        last_words <= wcnt;
      end
    end
  end

endmodule

// File: tb/tb_cam_capture_param.sv
// Randomised self-checking bench for cam_capture_param with a frame-level model.
module tb_cam_capture_param;

  localparam int H = 16;
  localparam int V = 12;
  localparam int AW = 8;
  localparam int DEPTH = 64;

  logic          pclk = 1'b0;
  logic          rst_n, en, vsync, href;
  logic [1:0]    mode, decim;
  logic [7:0]    d;
  logic          wr;
  logic [AW-1:0] addr;
  logic [15:0]   dout;
  logic          frame_done;
  logic [15:0]   frame_cnt;
  logic [AW-1:0] last_words;
  logic          overflow, byte_err;

  cam_capture_param #(
    .H_ACTIVE  (H),
    .V_ACTIVE  (V),
    .ADDR_W    (AW),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .pclk       (pclk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode),
    .decim      (decim),
    .vsync      (vsync),
    .href       (href),
    .d          (d),
    .wr         (wr),
    .addr       (addr),
    .dout       (dout),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .last_words (last_words),
    .overflow   (overflow),
    .byte_err   (byte_err)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [15:0]   v;
  } wr_t;

  typedef struct packed {
    logic [15:0]   cnt;
    logic [AW-1:0] words;
    logic          ovf;
    logic          berr;
  } st_t;

  int total = 0;
  int bad = 0;
  wr_t wq[$];
  st_t dq[$];
  int frame_wr = 0;
  int done_wr = 0;
  logic [AW-1:0] last_addr_seen = '0;
  logic [15:0]   last_dout_seen = '0;
  logic [15:0]   m_cnt = '0;

  bit         f_en;
  logic [1:0] f_mode, f_dec;
  int         f_lines;
  int         f_len[16];
  bit         f_rand;
  logic [7:0] f_b0, f_b1;
  bit         f_cut;
  int         f_rst_line;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] fmt(input logic [1:0] m, input logic [15:0] p);
    case (m)
      2'd1:    return {4'h0, p[15:12], p[10:7], p[4:1]};
      2'd2:    return {8'h00, p[15:8]};
      default: return p;
    endcase
  endfunction

  task automatic tick(input logic v, input logic h, input logic [7:0] b);
    @(negedge pclk);
    vsync = v;
    href  = h;
    d     = b;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wr"}, wr, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_frame_cnt"}, frame_cnt, 0);
    chk({tag, "_last_words"}, last_words, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_byte_err"}, byte_err, 0);
  endtask

  // Model: per line, every byte pair becomes a pixel; kept pixels are those
  // whose column and line index are multiples of the decimation step.
  task automatic drive_frame();
    bit cap;
    bit last;
    int step, len, eff, m_words, gap;
    bit m_ovf, m_berr;
    logic [7:0] b[64];
    mode = f_mode;
    decim = f_dec;
    en = f_en;
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
    cap = f_en;
    m_words = 0;
    m_ovf = 0;
    m_berr = 0;
    step = (f_dec == 2'd0) ? 1 : (f_dec == 2'd1) ? 2 : 4;
    tick(1'b0, 1'b0, 8'h00);
    mode = 2'($urandom);
    decim = 2'($urandom);
    en = ~f_en;
    for (int r = 0; r < f_lines; r++) begin
      if (r == f_rst_line) begin
        @(negedge pclk);
        rst_n = 1'b0;
        href = 1'b0;
        vsync = 1'b0;
        @(posedge pclk);
        #1;
        check_zero("midrst");
        rst_n = 1'b1;
        cap = 0;
        wq.delete();
        m_cnt = '0;
        frame_wr = 0;
      end
      len = f_len[r];
      last = (r == f_lines - 1) && f_cut;
      for (int i = 0; i < len; i++)
        b[i] = f_rand ? 8'($urandom) : ((i % 2 == 0) ? f_b0 : f_b1);
      eff = last ? len - 1 : len;
      if (cap) begin
        for (int c = 0; c < eff / 2; c++) begin
          if ((c % step == 0) && (r % step == 0)) begin
            if (m_words < DEPTH) begin
              wq.push_back('{a: AW'(m_words), v: fmt(f_mode, {b[2*c], b[2*c+1]})});
              m_words++;
            end else begin
              m_ovf = 1;
            end
          end
        end
        if (!last && (len % 2 == 1)) m_berr = 1;
      end
      for (int i = 0; i < len; i++)
        tick(last && (i == len - 1), 1'b1, b[i]);
      if (!last) begin
        gap = 1 + $urandom_range(0, 2);
        repeat (gap) tick(1'b0, 1'b0, 8'h00);
      end
    end
    if (cap) begin
      m_cnt = m_cnt + 16'd1;
      dq.push_back('{cnt: m_cnt, words: AW'(m_words), ovf: m_ovf, berr: m_berr});
    end
    repeat (3) tick(1'b1, 1'b0, 8'h00);
  endtask

  task automatic set_frame(input bit e, input logic [1:0] m, input logic [1:0] dc,
                           input bit rnd, input logic [7:0] b0, input logic [7:0] b1);
    f_en = e;
    f_mode = m;
    f_dec = dc;
    f_rand = rnd;
    f_b0 = b0;
    f_b1 = b1;
    f_lines = V;
    f_cut = 0;
    f_rst_line = -1;
    for (int i = 0; i < 16; i++) f_len[i] = 2 * H;
  endtask

  initial begin : compare
    wr_t e;
    st_t s;
    forever begin
      @(posedge pclk);
      #1;
      if (wr === 1'b1) begin
        if (wq.size() == 0) chk("wr_expected", wr, 0);
        else begin
          e = wq.pop_front();
          chk("wr_addr", addr, e.a);
          chk("wr_dout", dout, e.v);
        end
        frame_wr++;
        last_addr_seen = addr;
        last_dout_seen = dout;
      end
      if (frame_done === 1'b1) begin
        chk("pending_wr_at_done", wq.size(), 0);
        if (dq.size() == 0) chk("frame_done_expected", frame_done, 0);
        else begin
          s = dq.pop_front();
          chk("frame_cnt", frame_cnt, s.cnt);
          chk("last_words", last_words, s.words);
          chk("overflow", overflow, s.ovf);
          chk("byte_err", byte_err, s.berr);
        end
        done_wr = frame_wr;
        frame_wr = 0;
      end
    end
  end

  initial begin : stim
    rst_n = 1'b0;
    en = 1'b0;
    mode = 2'd0;
    decim = 2'd0;
    vsync = 1'b0;
    href = 1'b0;
    d = 8'h00;
    repeat (3) @(posedge pclk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    set_frame(1, 2'd0, 2'd0, 0, 8'hA5, 8'h3C);
    drive_frame();
    chk("f1_writes", done_wr, 64);
    chk("f1_last_addr", last_addr_seen, 63);
    chk("f1_dout", last_dout_seen, 16'hA53C);
    chk("f1_overflow", overflow, 1);
    chk("f1_last_words", last_words, 64);
    chk("f1_frame_cnt", frame_cnt, 1);

    set_frame(1, 2'd1, 2'd1, 0, 8'hF8, 8'h1F);
    drive_frame();
    chk("f2_writes", done_wr, 48);
    chk("f2_last_addr", last_addr_seen, 47);
    chk("f2_dout", last_dout_seen, 16'h0F0F);
    chk("f2_overflow", overflow, 0);

    set_frame(1, 2'd2, 2'd2, 0, 8'h80, 8'h10);
    drive_frame();
    chk("f3_writes", done_wr, 12);
    chk("f3_last_addr", last_addr_seen, 11);
    chk("f3_dout", last_dout_seen, 16'h0080);

    set_frame(0, 2'd0, 2'd0, 1, 8'h00, 8'h00);
    drive_frame();
    chk("skip_writes", frame_wr, 0);
    chk("skip_frame_cnt", frame_cnt, 3);

    set_frame(1, 2'd0, 2'd0, 1, 8'h00, 8'h00);
    f_len[5] = 2 * H - 1;
    f_cut = 1;
    drive_frame();
    chk("odd_byte_err", byte_err, 1);
    chk("odd_frame_cnt", frame_cnt, 4);

    set_frame(1, 2'd3, 2'd0, 1, 8'h00, 8'h00);
    drive_frame();
    chk("clean_byte_err", byte_err, 0);

    set_frame(1, 2'd0, 2'd0, 1, 8'h00, 8'h00);
    f_rst_line = 4;
    drive_frame();
    chk("rst_frame_writes", frame_wr, 0);
    chk("rst_frame_cnt", frame_cnt, 0);

    set_frame(1, 2'd0, 2'd0, 1, 8'h00, 8'h00);
    drive_frame();
    chk("post_rst_frame_cnt", frame_cnt, 1);

    for (int k = 0; k < 20; k++) begin
      set_frame($urandom_range(0, 3) != 0, 2'($urandom), 2'($urandom), 1, 8'h00, 8'h00);
      f_lines = $urandom_range(10, 14);
      for (int i = 0; i < 16; i++) begin
        f_len[i] = 2 * $urandom_range(10, 20);
        if ($urandom_range(0, 5) == 0) f_len[i] = f_len[i] - 1;
      end
      f_cut = $urandom_range(0, 1) != 0;
      drive_frame();
    end

    repeat (4) @(posedge pclk);
    #1;
    chk("frames_all_done", dq.size(), 0);
    chk("writes_all_done", wq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
